// File: rtl/mod_adder_pkg.sv
// mod_adder_pkg: shared width default and sum type for the modular adder
package mod_adder_pkg;
    localparam int MOD_ADDER_DEFAULT_BW = 32;
    typedef logic [MOD_ADDER_DEFAULT_BW:0] modSumT;
endpackage

// File: rtl/mod_adder_pipe_if.sv
// mod_adder_pipe_if: operand/result bundle of the modular adder
// oErr exists only when MOD_ADDER_RANGE_CHECK_EN is defined
interface mod_adder_pipe_if import mod_adder_pkg::*; #(parameter int BITWIDTH = MOD_ADDER_DEFAULT_BW);
    logic                iEn;
    logic                iClr;
    logic [BITWIDTH-1:0] iData0;
    logic [BITWIDTH-1:0] iData1;
    logic [BITWIDTH-1:0] iQ;
    logic                oValid;
    logic [BITWIDTH-1:0] oData;
`ifdef MOD_ADDER_RANGE_CHECK_EN
    logic                oErr;
    modport master (output iEn, iClr, iData0, iData1, iQ, input oValid, oData, oErr);
    modport slave  (input iEn, iClr, iData0, iData1, iQ, output oValid, oData, oErr);
`else
    modport master (output iEn, iClr, iData0, iData1, iQ, input oValid, oData);
    modport slave  (input iEn, iClr, iData0, iData1, iQ, output oValid, oData);
`endif
endinterface

// File: rtl/mod_reduce_cond_sub.sv
// mod_reduce_cond_sub: subtract q once if the carried sum reaches it
module mod_reduce_cond_sub #(parameter int BITWIDTH = 32) (
    input  logic [BITWIDTH:0]   sum,
    input  logic [BITWIDTH-1:0] q,
    output logic [BITWIDTH-1:0] res
);
    // low bits of (sum - q) equal the low bits of the full-width difference
    assign res = (sum >= {1'b0, q}) ? sum[BITWIDTH-1:0] - q : sum[BITWIDTH-1:0];
endmodule

// File: rtl/mod_adder_pipe.sv
// mod_adder_pipe: two-stage pipelined (a + b) mod q with runtime modulus
// optional range-error flag via MOD_ADDER_RANGE_CHECK_EN
module mod_adder_pipe import mod_adder_pkg::*; #(parameter int BITWIDTH = MOD_ADDER_DEFAULT_BW) (
    input logic iClk,
    input logic iRst,
    mod_adder_pipe_if.slave bus
);
    typedef logic [BITWIDTH:0] sumT;
    sumT                 sum1;
    logic [BITWIDTH-1:0] q1;
    logic                v1;
    logic [BITWIDTH-1:0] red;

    always_ff @(posedge iClk) begin
        if (iRst || bus.iClr) begin
            sum1 <= '0;
            q1   <= '0;
            v1   <= 1'b0;
        end else begin
            v1 <= bus.iEn;
            if (bus.iEn) begin
                sum1 <= {1'b0, bus.iData0} + {1'b0, bus.iData1};
                q1   <= bus.iQ;
            end
        end
    end

    mod_reduce_cond_sub #(.BITWIDTH(BITWIDTH)) uReduce (.sum(sum1), .q(q1), .res(red));

    always_ff @(posedge iClk) begin
        if (iRst || bus.iClr) begin
            bus.oValid <= 1'b0;
            bus.oData  <= '0;
        end else begin
            bus.oValid <= v1;
            if (v1) bus.oData <= red;
        end
    end

`ifdef MOD_ADDER_RANGE_CHECK_EN
    logic err1;
    always_ff @(posedge iClk) begin
        if (iRst || bus.iClr) begin
            err1     <= 1'b0;
            bus.oErr <= 1'b0;
        end else begin
            if (bus.iEn) err1 <= (bus.iData0 >= bus.iQ) || (bus.iData1 >= bus.iQ) || (bus.iQ == '0);
            bus.oErr <= v1 && err1;
        end
    end
`endif
endmodule

// File: tb/tb_mod_adder_pipe.sv
// tb_mod_adder_pipe: directed table, random stream and flush checks
module tb_mod_adder_pipe;
    logic clk = 1'b0;
    logic rst;
    int   nCmp = 0;
    int   nErr = 0;

    mod_adder_pipe_if #(.BITWIDTH(32)) bus();

    mod_adder_pipe #(.BITWIDTH(32)) dut (.iClk(clk), .iRst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] expData;
        logic        expErr;
    } vecT;

    vecT tbl[10];
    int  expArr[100];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
        bus.iEn    = 1'b1;
        bus.iData0 = a;
        bus.iData1 = b;
        bus.iQ     = q;
    endtask

    initial begin
        tbl[0] = '{32'd10, 32'd5, 32'd23, 32'd15, 1'b0};
        tbl[1] = '{32'd20, 32'd7, 32'd23, 32'd4, 1'b0};
        tbl[2] = '{32'd22, 32'd22, 32'd23, 32'd21, 1'b0};
        tbl[3] = '{32'd0, 32'd0, 32'd23, 32'd0, 1'b0};
        tbl[4] = '{32'd22, 32'd1, 32'd23, 32'd0, 1'b0};
        tbl[5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[6] = '{32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        tbl[7] = '{32'd23, 32'd1, 32'd23, 32'd1, 1'b1};
        tbl[8] = '{32'd5, 32'd6, 32'd0, 32'd11, 1'b1};
        tbl[9] = '{32'd5, 32'd6, 32'd23, 32'd11, 1'b0};

        rst = 1'b1;
        bus.iClr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive($urandom, $urandom, $urandom);
            tick();
            chk("rst_valid", 32'(bus.oValid), 32'd0);
            chk("rst_data", bus.oData, 32'd0);
        end
        rst = 1'b0;
        drive(32'd1, 32'd2, 32'd23);
        tick();
        chk("rel_valid_lat1", 32'(bus.oValid), 32'd0);
        bus.iEn = 1'b0;
        tick();
        chk("rel_valid_lat2", 32'(bus.oValid), 32'd1);
        chk("rel_data", bus.oData, 32'd3);
        tick();

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].q);
            tick();
            bus.iEn = 1'b0;
            chk("tbl_valid_early", 32'(bus.oValid), 32'd0);
            tick();
            chk("tbl_valid", 32'(bus.oValid), 32'd1);
            chk("tbl_data", bus.oData, tbl[i].expData);
`ifdef MOD_ADDER_RANGE_CHECK_EN
            chk("tbl_err", 32'(bus.oErr), 32'(tbl[i].expErr));
`endif
            tick();
            chk("tbl_valid_drop", 32'(bus.oValid), 32'd0);
            chk("tbl_data_hold", bus.oData, tbl[i].expData);
`ifdef MOD_ADDER_RANGE_CHECK_EN
            chk("tbl_err_idle", 32'(bus.oErr), 32'd0);
`endif
        end

        // modulus changes every cycle, each result uses its own q
        drive(32'd20, 32'd7, 32'd23);
        tick();
        drive(32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF);
        tick();
        chk("qchg_d0", bus.oData, 32'd4);
        drive(32'd5, 32'd6, 32'd7);
        tick();
        bus.iEn = 1'b0;
        chk("qchg_d1", bus.oData, 32'hFFFFFFFD);
        tick();
        chk("qchg_d2", bus.oData, 32'd4);
        chk("qchg_v2", 32'(bus.oValid), 32'd1);
        tick();

        for (int i = 0; i <= 100; i++) begin
            if (i < 100) begin
                int a, b;
                a = $urandom_range(0, 22);
                b = $urandom_range(0, 22);
                expArr[i] = (a + b) % 23;
                drive(32'(a), 32'(b), 32'd23);
            end else begin
                bus.iEn = 1'b0;
            end
            tick();
            if (i >= 1) begin
                chk("rnd_valid", 32'(bus.oValid), 32'd1);
                chk("rnd_data", bus.oData, 32'(expArr[i-1]));
            end
        end
        tick();
        chk("rnd_valid_end", 32'(bus.oValid), 32'd0);

        drive(32'd10, 32'd5, 32'd23);
        tick();
        bus.iEn = 1'b0;
        tick();
        tick();
        chk("fl_pre_data", bus.oData, 32'd15);
        drive(32'd1, 32'd1, 32'd23);
        tick();
        drive(32'd2, 32'd2, 32'd23);
        tick();
        drive(32'd3, 32'd3, 32'd23);
        bus.iClr = 1'b1;
        tick();
        bus.iClr = 1'b0;
        bus.iEn = 1'b0;
        chk("fl_valid0", 32'(bus.oValid), 32'd0);
        chk("fl_data0", bus.oData, 32'd0);
        tick();
        chk("fl_valid1", 32'(bus.oValid), 32'd0);
        chk("fl_data1", bus.oData, 32'd0);
        tick();
        chk("fl_valid2", 32'(bus.oValid), 32'd0);
        drive(32'd4, 32'd5, 32'd23);
        tick();
        bus.iEn = 1'b0;
        chk("fl_new_early", 32'(bus.oValid), 32'd0);
        tick();
        chk("fl_new_valid", 32'(bus.oValid), 32'd1);
        chk("fl_new_data", bus.oData, 32'd9);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
